// File: rtl/if_id_stage_if.sv
// if_id_stage_if: groups the fetch/decode front end's preload, pipeline
// control and ID/EX output bundle into one connection.
//   imem_we/imem_addr/imem_wdata : instruction memory preload port
//   stall, branch_taken, branch_target_in : pipeline control from execute
//   ALUop, rs, rt, rd, SEin, control bits, branch_target, valid, illegal :
//     registered ID/EX bundle toward the execute stage
// slave modport is used by the stage itself, master by whoever drives it.
interface if_id_stage_if #(
   parameter int unsigned IMEM_AW = 6
);
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;
   logic               stall;
   logic               branch_taken;
   logic [31:0]        branch_target_in;

   logic [1:0]         ALUop;
   logic [4:0]         rs;
   logic [4:0]         rt;
   logic [4:0]         rd;
   logic [15:0]        SEin;
   logic               RegWrite;
   logic               RegDst;
   logic               ALUSrc;
   logic               MemtoReg;
   logic               MemWrite;
   logic               MemRead;
   logic               Branch;
   logic [31:0]        branch_target;
   logic               valid;
   logic               illegal;

   modport master (
      output imem_we, imem_addr, imem_wdata, stall, branch_taken, branch_target_in,
      input  ALUop, rs, rt, rd, SEin, RegWrite, RegDst, ALUSrc, MemtoReg,
             MemWrite, MemRead, Branch, branch_target, valid, illegal
   );

   modport slave (
      input  imem_we, imem_addr, imem_wdata, stall, branch_taken, branch_target_in,
      output ALUop, rs, rt, rd, SEin, RegWrite, RegDst, ALUSrc, MemtoReg,
             MemWrite, MemRead, Branch, branch_target, valid, illegal
   );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: fetch/decode front end. Holds the PC and a preloadable
// word-addressed instruction memory, registers the fetched word in IF/ID,
// decodes it and registers the execute-stage control bundle at ID/EX.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (memory contents not reset)
//   bus     : preload port, stall/branch redirect in, ID/EX bundle out
module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IMEM_AW  = 6
) (
   input  logic          clock,
   input  logic          reset_n,
   if_id_stage_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << IMEM_AW;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'h00,
      OP_BEQ   = 6'h04,
      OP_ADDI  = 6'h08,
      OP_LW    = 6'h23,
      OP_SW    = 6'h2B
   } opcode_e;

   // ---------------- instruction memory ----------------
   logic [31:0] imem_q [DEPTH];
   logic [31:0] fetch_word;

   always_ff @(posedge clock) begin
      if (bus.imem_we) begin
         imem_q[bus.imem_addr] <= bus.imem_wdata;
      end
   end

   // Upper PC bits are ignored, so fetch addresses wrap modulo the depth.
   // The write above lands at the edge, so a same-cycle fetch sees the old word.
   logic [31:0] pc_q, pc_d;
   assign fetch_word = imem_q[pc_q[IMEM_AW+1:2]];

   // ---------------- PC and IF/ID ----------------
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc4_q,   if_pc4_d;

   always_comb begin
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc4_d   = if_pc4_q;
      if (bus.branch_taken) begin
         pc_d       = bus.branch_target_in;
         if_valid_d = 1'b0;
      end else if (!bus.stall) begin
         pc_d       = pc_q + 32'd4;
         if_valid_d = 1'b1;
         if_instr_d = fetch_word;
         if_pc4_d   = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc4_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc4_q   <= if_pc4_d;
      end
   end

   // ---------------- decode ----------------
   logic [5:0]  opcode;
   logic [15:0] imm;
   logic        dec_regdst, dec_alusrc, dec_memtoreg, dec_regwrite;
   logic        dec_memread, dec_memwrite, dec_branch, dec_illegal;
   logic [1:0]  dec_aluop;

   assign opcode = if_instr_q[31:26];
   assign imm    = if_instr_q[15:0];

   always_comb begin
      dec_regdst   = 1'b0;
      dec_alusrc   = 1'b0;
      dec_memtoreg = 1'b0;
      dec_regwrite = 1'b0;
      dec_memread  = 1'b0;
      dec_memwrite = 1'b0;
      dec_branch   = 1'b0;
      dec_aluop    = 2'b00;
      dec_illegal  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_regdst   = 1'b1;
            dec_regwrite = 1'b1;
            dec_aluop    = 2'b10;
         end
         OP_LW: begin
            dec_alusrc   = 1'b1;
            dec_memtoreg = 1'b1;
            dec_regwrite = 1'b1;
            dec_memread  = 1'b1;
         end
         OP_SW: begin
            dec_alusrc   = 1'b1;
            dec_memwrite = 1'b1;
         end
         OP_BEQ: begin
            dec_branch   = 1'b1;
            dec_aluop    = 2'b01;
         end
         OP_ADDI: begin
            dec_alusrc   = 1'b1;
            dec_regwrite = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // ---------------- ID/EX ----------------
   logic [8:0]  ctrl_q, ctrl_d;   // {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop}
   logic [4:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic [15:0] sein_q, sein_d;
   logic [31:0] bt_q, bt_d;
   logic        valid_q, valid_d, illegal_q, illegal_d;
   logic        bubble;

   // A redirect also kills whatever sits in IF/ID this cycle (the branch shadow).
   assign bubble = bus.branch_taken | bus.stall | ~if_valid_q;

   always_comb begin
      ctrl_d    = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      sein_d    = sein_q;
      bt_d      = bt_q;
      if (!bubble) begin
         ctrl_d    = {dec_regdst, dec_alusrc, dec_memtoreg, dec_regwrite,
                      dec_memread, dec_memwrite, dec_branch, dec_aluop};
         valid_d   = 1'b1;
         illegal_d = dec_illegal;
         rs_d      = if_instr_q[25:21];
         rt_d      = if_instr_q[20:16];
         rd_d      = if_instr_q[15:11];
         sein_d    = imm;
         bt_d      = if_pc4_q + {{14{imm[15]}}, imm, 2'b00};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         sein_q    <= '0;
         bt_q      <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         sein_q    <= sein_d;
         bt_q      <= bt_d;
      end
   end

   assign bus.RegDst        = ctrl_q[8];
   assign bus.ALUSrc        = ctrl_q[7];
   assign bus.MemtoReg      = ctrl_q[6];
   assign bus.RegWrite      = ctrl_q[5];
   assign bus.MemRead       = ctrl_q[4];
   assign bus.MemWrite      = ctrl_q[3];
   assign bus.Branch        = ctrl_q[2];
   assign bus.ALUop         = ctrl_q[1:0];
   assign bus.rs            = rs_q;
   assign bus.rt            = rt_q;
   assign bus.rd            = rd_q;
   assign bus.SEin          = sein_q;
   assign bus.branch_target = bt_q;
   assign bus.valid         = valid_q;
   assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed vectors for if_id_stage with hand-computed
// expectations; outputs are sampled 1 time unit after the rising edge.
module tb_if_id_stage;

   localparam int unsigned AW = 6;

   // Control packing: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUop}
   localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
   localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
   localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
   localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
   localparam logic [8:0] C_NONE = 9'b0;

   logic clock;
   logic reset_n;
   int   n_vec;
   int   n_bad;

   if_id_stage_if #(.IMEM_AW(AW)) bus ();

   if_id_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] ctrl_obs();
      return {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
              bus.MemRead, bus.MemWrite, bus.Branch, bus.ALUop};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".valid"},   64'(bus.valid),   64'd0);
      check({tag, ".ctrl"},    64'(ctrl_obs()),  64'(C_NONE));
      check({tag, ".illegal"}, 64'(bus.illegal), 64'd0);
   endtask

   task automatic check_instr(input string tag, input logic [8:0] ctrl,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [15:0] sein,
                              input logic ill);
      check({tag, ".valid"},   64'(bus.valid),   64'd1);
      check({tag, ".ctrl"},    64'(ctrl_obs()),  64'(ctrl));
      check({tag, ".rs"},      64'(bus.rs),      64'(rs));
      check({tag, ".rt"},      64'(bus.rt),      64'(rt));
      check({tag, ".rd"},      64'(bus.rd),      64'(rd));
      check({tag, ".SEin"},    64'(bus.SEin),    64'(sein));
      check({tag, ".illegal"}, 64'(bus.illegal), 64'(ill));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".ctrl"},  64'(ctrl_obs()), 64'(C_NONE));
      check({tag, ".flags"}, 64'({bus.valid, bus.illegal}), 64'd0);
      check({tag, ".fields"}, 64'({bus.rs, bus.rt, bus.rd, bus.SEin}), 64'd0);
      check({tag, ".btgt"},  64'(bus.branch_target), 64'd0);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   word;
   } preload_t;

   preload_t prog [8];

   initial begin
      n_vec = 0;
      n_bad = 0;
      prog[0] = '{6'd0,  32'h012A_4020};  // add  $8,$9,$10
      prog[1] = '{6'd1,  32'h8D28_0004};  // lw   $8,4($9)
      prog[2] = '{6'd2,  32'h1022_FFFE};  // beq  $1,$2,-2
      prog[3] = '{6'd3,  32'h2109_0005};  // addi $9,$8,5 (branch shadow)
      prog[4] = '{6'd4,  32'hAD2A_0008};  // sw   $10,8($9)
      prog[5] = '{6'd5,  32'hFC00_0000};  // opcode 0x3F
      prog[6] = '{6'd6,  32'h012A_4020};
      prog[7] = '{6'd63, 32'h1000_0001};  // beq $0,$0,+1 at last word

      reset_n              = 1'b0;
      bus.imem_we          = 1'b0;
      bus.imem_addr        = '0;
      bus.imem_wdata       = '0;
      bus.stall            = 1'b0;
      bus.branch_taken     = 1'b0;
      bus.branch_target_in = '0;

      for (int i = 0; i < 8; i++) begin
         bus.imem_we    = 1'b1;
         bus.imem_addr  = prog[i].addr;
         bus.imem_wdata = prog[i].word;
         tick();
      end
      bus.imem_we = 1'b0;
      check_all_zero("reset");

      reset_n = 1'b1;
      tick();                           // IF/ID <= add
      check_bubble("first_edge");
      tick();                           // add on outputs
      check_instr("add", C_R, 5'd9, 5'd10, 5'd8, 16'h4020, 1'b0);
      tick();                           // lw on outputs, IF/ID <= beq
      check_instr("lw", C_LW, 5'd9, 5'd8, 5'd0, 16'h0004, 1'b0);

      bus.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_bubble($sformatf("stall%0d", k));
      end
      bus.stall = 1'b0;
      tick();                           // held beq issues once, IF/ID <= addi
      check_instr("beq", C_BEQ, 5'd1, 5'd2, 5'd31, 16'hFFFE, 1'b0);
      check("beq.btgt", 64'(bus.branch_target), 64'h0000_0004);

      bus.branch_taken     = 1'b1;
      bus.branch_target_in = 32'h0000_0010;
      tick();                           // shadow addi flushed
      check_bubble("br_bubble0");
      bus.branch_taken = 1'b0;
      tick();
      check_bubble("br_bubble1");
      tick();
      check_instr("sw", C_SW, 5'd9, 5'd10, 5'd0, 16'h0008, 1'b0);
      tick();
      check_instr("illegal", C_NONE, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1);

      bus.branch_taken     = 1'b1;      // redirect must beat stall
      bus.stall            = 1'b1;
      bus.branch_target_in = 32'h0000_0000;
      tick();
      check_bubble("br_stall");
      bus.branch_taken = 1'b0;
      bus.stall        = 1'b0;
      tick();
      check_bubble("br_stall_b1");
      tick();
      check_instr("br_stall_tgt", C_R, 5'd9, 5'd10, 5'd8, 16'h4020, 1'b0);

      #2 reset_n = 1'b0;                // mid-cycle, well before next edge
      #1;
      check_all_zero("async_rst");
      tick();
      reset_n = 1'b1;
      tick();
      check_bubble("rst_rel0");
      tick();
      check_instr("rst_rel_add", C_R, 5'd9, 5'd10, 5'd8, 16'h4020, 1'b0);

      bus.branch_taken     = 1'b1;      // last word, then PC wraps to 0
      bus.branch_target_in = 32'hFFFF_FFFC;
      tick();
      bus.branch_taken = 1'b0;
      check_bubble("wrap_b0");
      tick();
      check_bubble("wrap_b1");
      tick();
      check_instr("wrap_beq", C_BEQ, 5'd0, 5'd0, 5'd0, 16'h0001, 1'b0);
      check("wrap_beq.btgt", 64'(bus.branch_target), 64'h0000_0004);
      tick();
      check_instr("wrap_add", C_R, 5'd9, 5'd10, 5'd8, 16'h4020, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch/decode front end of the pipeline. It directly feeds the register-file/ALU/data-memory execute stage.
- Holds the PC and a word-addressed instruction memory, which is preloadable through a write port.
- Registers the fetched instruction in an IF/ID register.
- Decodes opcode into the execute stage's control bundle (ALUop, RegWrite, RegDst, ALUSrc, MemtoReg, MemWrite, MemRead) plus rs/rt/rd/SEin, all registered at the ID/EX boundary.
- Supports stall (hold) and branch redirect/flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
IMEM_AW, 6, instruction memory address width in words (depth 2**IMEM_AW).

Ports:
clock  input  1  rising-edge clock, sole clock.
reset_n  input  1  asynchronous active-low reset.
imem_we  input  1  instruction memory write enable (preload).
imem_addr  input  IMEM_AW  preload word address.
imem_wdata  input  32  preload word.
stall  input  1  hold PC and IF/ID; insert bubble into ID/EX.
branch_taken  input  1  redirect from execute (Branch & Zero).
branch_target_in  input  32  redirect PC, used when branch_taken=1.
ALUop  output  2  00 add, 01 sub (beq), 10 funct-decoded.
rs  output  5  instr[25:21].
rt  output  5  instr[20:16].
rd  output  5  instr[15:11].
SEin  output  16  instr[15:0].
RegWrite, RegDst, ALUSrc, MemtoReg, MemWrite, MemRead, Branch  output  1 each  control bits.
branch_target  output  32  if_id_pc4 + ({{14{imm[15]}},imm,2'b00}).
valid  output  1  ID/EX holds a real instruction.
illegal  output  1  registered flag: decoded opcode unsupported.

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC; if_id_valid=0; if_id_instr=0; if_id_pc4=0.
  - Every output = 0.
  - Instruction memory contents are not reset.
- Instruction memory:
  - Synchronous write when imem_we=1.
  - Combinational read at pc[IMEM_AW+1:2]; upper PC bits ignored, so addresses wrap modulo depth.
  - Write and fetch of the same word in the same cycle: the fetch sees the old word.
- Fetch (each clock edge, priority order):
  - branch_taken: pc<=branch_target_in; IF/ID <= invalid (if_id_valid=0).
  - else stall: pc, IF/ID unchanged.
  - else: IF/ID <= {valid=1, instr=imem[pc], pc4=pc+4}; pc<=pc+4, 32-bit wrap at 0xFFFF_FFFC -> 0.
- Decode (combinational on IF/ID, by opcode instr[31:26]), listed as RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUop:
  - 0x00 R-type: 1 0 0 1 0 0 0 10.
  - 0x23 lw: 0 1 1 1 1 0 0 00.
  - 0x2B sw: 0 1 0 0 0 1 0 00.
  - 0x04 beq: 0 0 0 0 0 0 1 01.
  - 0x08 addi: 0 1 0 1 0 0 0 00.
  - any other opcode: all control 0, illegal=1.
- ID/EX output registers (each edge):
  - branch_taken=1 or stall=1 or if_id_valid=0: bubble. All seven control bits=0, ALUop=00, valid=0, illegal=0. rs/rt/rd/SEin/branch_target may keep stale values, but carry no side effects.
  - else: load decoded fields; valid=1.
- Latency:
  - Instruction at pc at edge N appears on outputs after edge N+1 (2 edges from PC presentation).
  - branch_taken at edge N: target's instruction on outputs after edge N+2.
  - Two bubbles follow a taken branch.
- Simultaneous events:
  - branch_taken and stall both asserted: branch_taken wins.
  - Stall asserted for k cycles: exactly k bubbles; the held instruction then issues once. No duplication, no loss.
- reset_n deasserted mid-stream: outputs clear immediately (async). The first valid output appears 2 edges after reset release.

Test Plan:
- Reset then preload imem[0]=0x012A4020 (add $8,$9,$10), release reset -> after 2nd edge: valid=1, rs=9, rt=10, rd=8, RegDst=1, RegWrite=1, ALUop=10, SEin=0x4020.
- imem[1]=0x8D280004 (lw $8,4($9)) following -> next cycle: MemRead=1, MemtoReg=1, ALUSrc=1, RegWrite=1, ALUop=00, SEin=0x0004, rt=8.
- Assert stall 3 cycles during straight-line code -> exactly 3 bubble cycles (valid=0, all control 0), PC frozen; then the next instruction issues once with no skips.
- beq at imem[2] with imm=0xFFFE -> branch_target = 0x0000000C + 0xFFFFFFF8 = 0x00000004. Drive branch_taken=1, branch_target_in=0x10 -> 2 bubble cycles, then imem[4] decoded.
- Opcode 0x3F -> valid=1, illegal=1, all control 0. branch_taken and stall together -> PC takes target, bubble issued.
- Assert reset_n=0 asynchronously mid-cycle -> all outputs 0 before the next edge; PC restarts at RESET_PC.
